// File: rtl/ma_load_unit.sv
// ma_load_unit: memory-access stage load handler.
// Captures the bus data-phase word, optionally spends one cycle on EDAC
// correction/detection, extracts and extends the addressed byte/half/word,
// and holds the registered result toward write-back until it is accepted.
module ma_load_unit #(
    parameter int CHECK_EN = 1
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_flush_i,
    input  logic        s_req_i,
    input  logic [2:0]  s_funct_i,
    input  logic [1:0]  s_addr_i,
    input  logic        s_dp_ready_i,
    input  logic        s_dp_hresp_i,
    input  logic [31:0] s_dp_data_i,
    input  logic [31:0] s_fixed_data_i,
    input  logic [1:0]  s_einfo_i,
    input  logic        s_wb_ready_i,
    output logic [31:0] s_read_data_o,
    output logic [31:0] s_result_o,
    output logic        s_valid_o,
    output logic [1:0]  s_exc_o,
    output logic        s_ce_o,
    output logic        s_busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_EDAC = 2'b01;
    localparam logic [1:0] EXC_BUS  = 2'b10;

    state_e      state_q, state_d;
    logic [2:0]  funct_q, funct_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  exc_q, exc_d;
    logic        capture;
    logic        ce_pulse;

    // Pick the addressed byte/half (half ignores addr[0]) and extend it;
    // funct[2] selects zero extension, otherwise sign extension.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [2:0]  funct,
                                            input logic [1:0]  addr);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (addr)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = addr[1] ? word[31:16] : word[15:0];
        case (funct[1:0])
            2'b00:   res = {{24{byte_v[7] & ~funct[2]}}, byte_v};
            2'b01:   res = {{16{half_v[15] & ~funct[2]}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // Next-state and datapath update; flush overrides everything, including a capture.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        funct_d     = funct_q;
        addr_d      = addr_q;
        read_data_d = read_data_q;
        result_d    = result_q;
        exc_d       = exc_q;
        capture     = 1'b0;
        ce_pulse    = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_req_i) begin
                    funct_d = s_funct_i;
                    addr_d  = s_addr_i;
                    if (s_dp_ready_i) capture = 1'b1;
                    else              state_d = WAIT;
                end
            end
            WAIT: begin
                if (s_dp_ready_i) capture = 1'b1;
            end
            CHECK: begin
                state_d = DONE;
                if (s_einfo_i[1]) begin
                    result_d = extract(s_fixed_data_i, funct_q, addr_q);
                    ce_pulse = 1'b1;
                end else if (s_einfo_i[0]) begin
                    result_d = '0;
                    exc_d    = EXC_EDAC;
                end else begin
                    result_d = extract(read_data_q, funct_q, addr_q);
                end
            end
            DONE: begin
                if (s_wb_ready_i) begin
                    state_d = IDLE;
                    exc_d   = EXC_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A bus error (even with ready in the same cycle) bypasses the EDAC cycle.
        if (capture) begin
            read_data_d = s_dp_data_i;
            if (s_dp_hresp_i) begin
                state_d  = DONE;
                exc_d    = EXC_BUS;
                result_d = '0;
            end else if (CHECK_EN != 0) begin
                state_d = CHECK;
                exc_d   = EXC_NONE;
            end else begin
                state_d  = DONE;
                exc_d    = EXC_NONE;
                result_d = extract(s_dp_data_i, funct_d, addr_d);
            end
        end

        if (s_flush_i) begin
            state_d     = IDLE;
            exc_d       = EXC_NONE;
            funct_d     = funct_q;
            addr_d      = addr_q;
            read_data_d = read_data_q;
            result_d    = result_q;
            ce_pulse    = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
        if (s_reset_i) begin
            state_q     <= IDLE;
            funct_q     <= '0;
            addr_q      <= '0;
            read_data_q <= '0;
            result_q    <= '0;
            exc_q       <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            funct_q     <= funct_d;
            addr_q      <= addr_d;
            read_data_q <= read_data_d;
            result_q    <= result_d;
            exc_q       <= exc_d;
        end
    end

    // Outputs; busy is forced low while reset is held even if a request is pending.
    always_comb begin
        s_read_data_o = read_data_q;
        s_result_o    = result_q;
        s_valid_o     = (state_q == DONE);
        s_exc_o       = exc_q;
        s_ce_o        = ce_pulse;
        s_busy_o      = 1'b0;
        if (!s_reset_i) begin
            case (state_q)
                IDLE:    s_busy_o = s_req_i;
                WAIT:    s_busy_o = 1'b1;
                CHECK:   s_busy_o = 1'b1;
                DONE:    s_busy_o = ~s_wb_ready_i;
                default: s_busy_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ma_load_unit.sv
// Testbench for ma_load_unit: directed scenarios plus randomized loads,
// checked by a scoreboard fed from a behavioural load model.
module tb_ma_load_unit;

    localparam int CHECK_EN = 1;

    logic        s_clk_i;
    logic        s_reset_i;
    logic        s_flush_i;
    logic        s_req_i;
    logic [2:0]  s_funct_i;
    logic [1:0]  s_addr_i;
    logic        s_dp_ready_i;
    logic        s_dp_hresp_i;
    logic [31:0] s_dp_data_i;
    logic [31:0] s_fixed_data_i;
    logic [1:0]  s_einfo_i;
    logic        s_wb_ready_i;
    logic [31:0] s_read_data_o;
    logic [31:0] s_result_o;
    logic        s_valid_o;
    logic [1:0]  s_exc_o;
    logic        s_ce_o;
    logic        s_busy_o;

    ma_load_unit #(.CHECK_EN(CHECK_EN)) dut (
        .s_clk_i        (s_clk_i),
        .s_reset_i      (s_reset_i),
        .s_flush_i      (s_flush_i),
        .s_req_i        (s_req_i),
        .s_funct_i      (s_funct_i),
        .s_addr_i       (s_addr_i),
        .s_dp_ready_i   (s_dp_ready_i),
        .s_dp_hresp_i   (s_dp_hresp_i),
        .s_dp_data_i    (s_dp_data_i),
        .s_fixed_data_i (s_fixed_data_i),
        .s_einfo_i      (s_einfo_i),
        .s_wb_ready_i   (s_wb_ready_i),
        .s_read_data_o  (s_read_data_o),
        .s_result_o     (s_result_o),
        .s_valid_o      (s_valid_o),
        .s_exc_o        (s_exc_o),
        .s_ce_o         (s_ce_o),
        .s_busy_o       (s_busy_o)
    );

    typedef struct {
        logic [31:0] result;
        logic [1:0]  exc;
        logic [31:0] read_data;
        int          ce;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ce_seen  = 0;

    initial begin
        s_clk_i = 1'b0;
        forever #5 s_clk_i = ~s_clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: what a load should return, from the rules on errors,
    // correction and byte/half/word extraction, using plain arithmetic.
    function automatic exp_t model(input logic [2:0] f, input logic [1:0] a,
                                   input logic [31:0] d, input logic [31:0] fx,
                                   input logic [1:0] ei, input logic hr);
        exp_t e;
        logic [31:0] word;
        longint unsigned fld, lim;
        int width, shift;
        e.read_data = d;
        e.exc       = 2'b00;
        e.ce        = 0;
        e.result    = '0;
        if (hr) begin
            e.exc = 2'b10;
            return e;
        end
        if (CHECK_EN != 0 && ei[1]) begin
            word = fx;
            e.ce = 1;
        end else if (CHECK_EN != 0 && ei[0]) begin
            e.exc = 2'b01;
            return e;
        end else begin
            word = d;
        end
        case (f[1:0])
            2'b00:   begin width = 8;  shift = 8 * int'(a);        end
            2'b01:   begin width = 16; shift = 16 * (int'(a) / 2); end
            default: begin width = 32; shift = 0;                  end
        endcase
        lim = 64'd1 << width;
        fld = ({32'd0, word} >> shift) % lim;
        if (f[2] == 1'b0 && width < 32 && fld >= lim / 2)
            fld = fld + (64'd1 << 32) - lim;
        e.result = fld[31:0];
        return e;
    endfunction

    // Monitor: counts correction pulses and checks every accepted result.
    always @(negedge s_clk_i) begin
        exp_t e;
        if (s_ce_o) ce_seen++;
        if (!s_reset_i && s_valid_o && s_wb_ready_i) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_result", s_result_o, e.result);
                check("sb_exc", 32'(s_exc_o), 32'(e.exc));
                check("sb_read_data", s_read_data_o, e.read_data);
            end
        end
    end

    task automatic idle_inputs();
        s_req_i      = 1'b0;
        s_dp_ready_i = 1'b0;
        s_dp_hresp_i = 1'b0;
        s_flush_i    = 1'b0;
        s_wb_ready_i = 1'b0;
    endtask

    // One complete load: request, optional wait cycles, EDAC info, and
    // optional write-back back-pressure before acceptance.
    task automatic run_load(input logic [2:0] f, input logic [1:0] a,
                            input logic [31:0] d, input logic [31:0] fx,
                            input logic [1:0] ei, input logic hr,
                            input int waits, input int wbw);
        exp_t e;
        int   lat, ce0, exp_lat;
        e = model(f, a, d, fx, ei, hr);
        sb_q.push_back(e);
        exp_lat = (hr || CHECK_EN == 0) ? 1 : 2;
        @(posedge s_clk_i); #1;
        ce0 = ce_seen;
        s_req_i   = 1'b1;
        s_funct_i = f;
        s_addr_i  = a;
        for (int w = 0; w <= waits; w++) begin
            s_dp_ready_i = (w == waits);
            s_dp_data_i  = (w == waits) ? d  : $urandom;
            s_dp_hresp_i = (w == waits) ? hr : 1'($urandom);
            #1;
            check("busy_request", 32'(s_busy_o), 32'd1);
            @(posedge s_clk_i); #1;
        end
        s_req_i        = 1'b0;
        s_dp_ready_i   = 1'b0;
        s_dp_hresp_i   = 1'b0;
        s_dp_data_i    = $urandom;
        s_einfo_i      = ei;
        s_fixed_data_i = fx;
        s_wb_ready_i   = 1'b0;
        lat = 1;
        #1;
        while (!s_valid_o && lat < 8) begin
            @(posedge s_clk_i); #2;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        s_einfo_i      = 2'($urandom);
        s_fixed_data_i = $urandom;
        for (int h = 0; h < wbw; h++) begin
            #1;
            check("hold_valid", 32'(s_valid_o), 32'd1);
            check("hold_busy", 32'(s_busy_o), 32'd1);
            check("hold_result", s_result_o, e.result);
            @(posedge s_clk_i); #2;
        end
        s_wb_ready_i = 1'b1;
        #1;
        check("busy_on_accept", 32'(s_busy_o), 32'd0);
        @(posedge s_clk_i); #1;
        s_wb_ready_i = 1'b0;
        #1;
        check("idle_after_accept", 32'(s_valid_o), 32'd0);
        check("ce_pulses", 32'(ce_seen - ce0), 32'(e.ce));
    endtask

    initial begin
        int ce0;
        logic [2:0] rf;
        s_reset_i      = 1'b1;
        s_flush_i      = 1'b0;
        s_req_i        = 1'b1;
        s_funct_i      = 3'b010;
        s_addr_i       = 2'd0;
        s_dp_ready_i   = 1'b1;
        s_dp_hresp_i   = 1'b0;
        s_dp_data_i    = 32'hDEAD_BEEF;
        s_fixed_data_i = 32'h0;
        s_einfo_i      = 2'b00;
        s_wb_ready_i   = 1'b0;

        // Reset holds every output low, busy included despite a pending request.
        #22;
        check("rst_busy", 32'(s_busy_o), 32'd0);
        check("rst_valid", 32'(s_valid_o), 32'd0);
        check("rst_result", s_result_o, 32'd0);
        check("rst_read_data", s_read_data_o, 32'd0);
        check("rst_exc", 32'(s_exc_o), 32'd0);
        check("rst_ce", 32'(s_ce_o), 32'd0);
        @(posedge s_clk_i); #1;
        idle_inputs();
        s_reset_i = 1'b0;

        // Directed scenarios.
        run_load(3'b000, 2'd3, 32'h80FF_1234, 32'h0,         2'b00, 1'b0, 0, 0); // LB
        run_load(3'b101, 2'd2, 32'h0000_0000, 32'hBEEF_0000, 2'b10, 1'b0, 0, 0); // LHU corrected
        run_load(3'b010, 2'd0, 32'h1234_5678, 32'h0,         2'b00, 1'b1, 3, 0); // LW bus error
        run_load(3'b010, 2'd0, 32'hCAFE_F00D, 32'h0,         2'b01, 1'b0, 0, 3); // LW uncorrectable
        run_load(3'b001, 2'd3, 32'h8001_7FFF, 32'h0,         2'b00, 1'b0, 1, 1); // LH, addr[0] ignored
        run_load(3'b100, 2'd0, 32'h1111_11F0, 32'h0,         2'b11, 1'b1, 0, 0); // error with ready, einfo ignored

        // Flush during CHECK: no result, no correction pulse.
        @(posedge s_clk_i); #1;
        s_req_i = 1'b1; s_funct_i = 3'b010; s_addr_i = 2'd0;
        s_dp_ready_i = 1'b1; s_dp_hresp_i = 1'b0; s_dp_data_i = $urandom;
        @(posedge s_clk_i); #1;
        ce0 = ce_seen;
        s_req_i = 1'b0; s_dp_ready_i = 1'b0;
        s_einfo_i = 2'b10; s_fixed_data_i = $urandom; s_flush_i = 1'b1;
        #1;
        check("flush_ce_low", 32'(s_ce_o), 32'd0);
        @(posedge s_clk_i); #1;
        s_flush_i = 1'b0;
        #1;
        check("flush_valid", 32'(s_valid_o), 32'd0);
        check("flush_exc", 32'(s_exc_o), 32'd0);
        check("flush_busy", 32'(s_busy_o), 32'd0);
        check("flush_ce_count", 32'(ce_seen - ce0), 32'd0);
        @(posedge s_clk_i); #2;
        check("flush_valid_later", 32'(s_valid_o), 32'd0);
        run_load(3'b100, 2'd1, 32'h0000_AB00, 32'h0, 2'b00, 1'b0, 0, 0); // LBU

        // Reset during WAIT: aborts the load outright.
        @(posedge s_clk_i); #1;
        s_req_i = 1'b1; s_funct_i = 3'b010; s_addr_i = 2'd0; s_dp_ready_i = 1'b0;
        @(posedge s_clk_i); #1;
        check("wait_busy", 32'(s_busy_o), 32'd1);
        s_reset_i = 1'b1;
        #1;
        check("midrst_busy", 32'(s_busy_o), 32'd0);
        check("midrst_valid", 32'(s_valid_o), 32'd0);
        check("midrst_read_data", s_read_data_o, 32'd0);
        check("midrst_result", s_result_o, 32'd0);
        check("midrst_exc", 32'(s_exc_o), 32'd0);
        @(posedge s_clk_i); #1;
        ce0 = ce_seen;
        s_reset_i = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(posedge s_clk_i); #2;
            check("post_rst_valid", 32'(s_valid_o), 32'd0);
            check("post_rst_busy", 32'(s_busy_o), 32'd0);
        end
        check("post_rst_ce", 32'(ce_seen - ce0), 32'd0);
        run_load(3'b100, 2'd1, 32'h0000_AB00, 32'h0, 2'b00, 1'b0, 0, 0); // LBU

        // Randomized loads.
        for (int n = 0; n < 60; n++) begin
            rf = {1'($urandom), 2'($urandom_range(0, 2))};
            run_load(rf, 2'($urandom), $urandom, $urandom, 2'($urandom),
                     ($urandom_range(0, 4) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        @(posedge s_clk_i); #2;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ma_load_unit.md
MA_LOAD_UNIT -- requirements
Module: ma_load_unit

Interface
REQ-001 Parameter CHECK_EN, default 1, meaning: 1 = insert one EDAC check cycle after data capture; 0 = skip it.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 s_clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 s_reset_i  input  1  asynchronous, active-high reset.
REQ-005 s_flush_i  input  1  pipeline flush; kills the in-flight load.
REQ-006 s_req_i  input  1  MA stage holds a load in its data phase.
REQ-007 s_funct_i  input  3  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned.
REQ-008 s_addr_i  input  2  low address bits of the load.
REQ-009 s_dp_ready_i  input  1  bus data-phase ready.
REQ-010 s_dp_hresp_i  input  1  bus error response.
REQ-011 s_dp_data_i  input  32  bus read data.
REQ-012 s_fixed_data_i  input  32  corrected word returned by LSU for s_read_data_o.
REQ-013 s_einfo_i  input  2  {ce, error} for the captured word, valid in CHECK.
REQ-014 s_wb_ready_i  input  1  write-back stage accepts the result.
REQ-015 s_read_data_o  output  32  captured raw word.
REQ-016 s_result_o  output  32  extracted, extended load result.
REQ-017 s_valid_o  output  1  result/exception valid toward write-back.
REQ-018 s_exc_o  output  2  {bus error, uncorrectable EDAC error}.
REQ-019 s_ce_o  output  1  one-cycle pulse on a corrected error.
REQ-020 s_busy_o  output  1  MA stage must stall.

Function
REQ-021 The FSM SHALL have states IDLE, WAIT, CHECK and DONE.
REQ-022 IDLE with s_req_i=1 and s_flush_i=0 SHALL latch funct/addr and behave as follows:
- s_dp_ready_i=1: capture the data and go to CHECK (CHECK_EN=1) or DONE (CHECK_EN=0).
- otherwise: go to WAIT.
REQ-023 WAIT SHALL stay in WAIT while s_dp_ready_i=0, and on s_dp_ready_i=1 capture and move as in REQ-022.
REQ-024 Capture SHALL load s_read_data_o with s_dp_data_i and the bus-error flag with s_dp_hresp_i.
REQ-025 A captured bus error SHALL go straight to DONE (skipping CHECK) with s_exc_o=2'b10 and s_result_o=0.
REQ-026 CHECK SHALL last exactly one cycle and then go to DONE, selecting the result source from s_einfo_i:
- ce=1: take s_fixed_data_i and pulse s_ce_o for that cycle.
- ce=0, error=1: set s_exc_o=2'b01 and force the result to 0.
- einfo=00: take s_read_data_o.
REQ-027 The selected word SHALL be registered, so s_result_o is stable throughout DONE.
REQ-028 Byte loads SHALL take word[8*addr+7:8*addr]; half loads SHALL take word[16*addr[1]+15:16*addr[1]] and ignore addr[0]; word loads SHALL take the whole word.
REQ-029 Byte and half results SHALL be sign-extended when funct[2]=0 and zero-extended when funct[2]=1.
REQ-030 DONE SHALL assert s_valid_o; on s_wb_ready_i=1 the FSM SHALL return to IDLE, with no new request accepted in that same cycle.
REQ-031 s_busy_o SHALL be high in WAIT and CHECK, in DONE while s_wb_ready_i=0, and in IDLE when s_req_i=1.
REQ-032 s_flush_i=1 in any state SHALL force IDLE on the next edge, clear s_valid_o and s_exc_o, suppress s_ce_o, and ignore any concurrent capture.
REQ-033 Simultaneous s_dp_ready_i=1 and s_dp_hresp_i=1 SHALL be treated as a bus error; s_einfo_i is not sampled for that load.
REQ-034 Latency SHALL be s_req_i with s_dp_ready_i=1 at edge N -> s_valid_o at N+2 (CHECK_EN=1) or N+1 (CHECK_EN=0).

Reset
REQ-035 While s_reset_i=1 the FSM SHALL be IDLE and s_read_data_o, s_result_o, s_valid_o, s_exc_o, s_ce_o and s_busy_o SHALL all be 0, with s_busy_o held low regardless of s_req_i.
REQ-036 Reset asserted mid-operation SHALL abort the load immediately with no s_valid_o or s_ce_o afterwards.

Verification
REQ-037 LB, addr=3, data 0x80FF_1234, einfo=00, CHECK_EN=1 -> s_valid_o two cycles later, result 0xFFFF_FF80, exc 00.
REQ-038 LHU, addr=2, data 0x0000_0000, fixed 0xBEEF_0000, einfo=10 -> result 0x0000_BEEF, s_ce_o one pulse in CHECK, exc 00.
REQ-039 LW, three cycles of dp_ready=0 then ready with hresp=1 -> busy for 4 cycles, valid with exc 10, result 0, no CHECK cycle.
REQ-040 LW, einfo=01 -> exc 01, result 0; then s_wb_ready_i held low for 3 cycles -> valid, result and busy held, and IDLE the cycle after wb_ready rises.
REQ-041 s_flush_i during CHECK, and separately s_reset_i during WAIT -> IDLE next cycle, valid=0, ce=0, exc=00, and the next LBU addr=1, data 0x0000_AB00 returns 0x0000_00AB.
